// File: rtl/ucsbece154a_instr_encoder_pkg.sv
// Shared constants for the instruction encoder: request kind codes, ALU
// select codes and the RV32I opcode/funct3/funct7 values. These are the same
// values the single-cycle controller decodes. The package also holds the
// encoder FSM state type.
package ucsbece154a_instr_encoder_pkg;

   // request kinds (req_kind_i)
   localparam logic [2:0] KIND_LW    = 3'd0;
   localparam logic [2:0] KIND_SW    = 3'd1;
   localparam logic [2:0] KIND_RTYPE = 3'd2;
   localparam logic [2:0] KIND_BEQ   = 3'd3;
   localparam logic [2:0] KIND_ITYPE = 3'd4;
   localparam logic [2:0] KIND_JAL   = 3'd5;
   localparam logic [2:0] KIND_LUI   = 3'd6;

   // ALU selects (alu_sel_i); codes 4, 6 and 7 are unassigned
   localparam logic [2:0] ALU_ADD = 3'd0;
   localparam logic [2:0] ALU_SUB = 3'd1;
   localparam logic [2:0] ALU_AND = 3'd2;
   localparam logic [2:0] ALU_OR  = 3'd3;
   localparam logic [2:0] ALU_SLT = 3'd5;

   // opcodes
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;

   // funct3
   localparam logic [2:0] F3_ADD_SUB = 3'b000;
   localparam logic [2:0] F3_SLT     = 3'b010;
   localparam logic [2:0] F3_OR      = 3'b110;
   localparam logic [2:0] F3_AND     = 3'b111;
   localparam logic [2:0] F3_WORD    = 3'b010;
   localparam logic [2:0] F3_BEQ     = 3'b000;

   // funct7
   localparam logic [6:0] F7_SUB     = 7'b0100000;
   localparam logic [6:0] F7_DEFAULT = 7'b0000000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FULL = 2'd2
   } enc_state_e;

   // true when the upper bits of v are a pure sign extension from bit 'top'
   function automatic logic fits_signed(input logic [31:0] v, input int top);
      logic all_one;
      logic all_zero;
      all_one  = 1'b1;
      all_zero = 1'b1;
      for (int i = 0; i < 32; i++) begin
         if (i >= top) begin
            all_one  = all_one & v[i];
            all_zero = all_zero & ~v[i];
         end
      end
      return all_one | all_zero;
   endfunction

endpackage

// File: rtl/ucsbece154a_instr_encoder_if.sv
// Request bus into the instruction encoder.
//   req_valid  request present
//   req_ready  encoder accepts this cycle (driven by the encoder)
//   req_kind   instruction kind code
//   alu_sel    ALU operation for RTYPE/ITYPE
//   rd/rs1/rs2 register indices
//   imm        byte offset / immediate (two's complement), LUI upper value
interface ucsbece154a_instr_encoder_if;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_kind;
   logic [2:0]  alu_sel;
   logic [4:0]  rd;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [31:0] imm;

   modport master (
      output req_valid, req_kind, alu_sel, rd, rs1, rs2, imm,
      input  req_ready
   );

   modport slave (
      input  req_valid, req_kind, alu_sel, rd, rs1, rs2, imm,
      output req_ready
   );
endinterface

// File: rtl/ucsbece154a_instr_encoder_pack.sv
// Pure combinational field-to-word packer for the instruction encoder.
// Ports:
//   kind_i, alu_sel_i        request kind and ALU select
//   rd_i, rs1_i, rs2_i       register indices (unused fields ignored)
//   imm_i                    immediate / offset
//   word_o                   encoded RV32I instruction
//   legal_o                  request is encodable
module ucsbece154a_instr_pack (
   input  logic [2:0]  kind_i,
   input  logic [2:0]  alu_sel_i,
   input  logic [4:0]  rd_i,
   input  logic [4:0]  rs1_i,
   input  logic [4:0]  rs2_i,
   input  logic [31:0] imm_i,
   output logic [31:0] word_o,
   output logic        legal_o
);
   import ucsbece154a_instr_encoder_pkg::*;

   logic [2:0] alu_f3;
   logic       alu_ok;
   logic       alu_sub;
   logic       imm12_ok;
   logic       imm13_ok;
   logic       imm21_ok;
   logic       lui_ok;

   // 12-bit signed for I/S, 13-bit even for B, 21-bit even for J
   assign imm12_ok = fits_signed(imm_i, 11);
   assign imm13_ok = fits_signed(imm_i, 12) & ~imm_i[0];
   assign imm21_ok = fits_signed(imm_i, 20) & ~imm_i[0];
   assign lui_ok   = (imm_i[11:0] == 12'd0);

   always_comb begin
      alu_f3  = F3_ADD_SUB;
      alu_ok  = 1'b1;
      alu_sub = 1'b0;
      case (alu_sel_i)
         ALU_ADD: alu_f3  = F3_ADD_SUB;
         ALU_SUB: alu_sub = 1'b1;
         ALU_AND: alu_f3  = F3_AND;
         ALU_OR:  alu_f3  = F3_OR;
         ALU_SLT: alu_f3  = F3_SLT;
         default: alu_ok  = 1'b0;
      endcase
   end

   always_comb begin
      word_o  = 32'd0;
      legal_o = 1'b0;
      case (kind_i)
         KIND_LW: begin
            word_o  = {imm_i[11:0], rs1_i, F3_WORD, rd_i, OP_LOAD};
            legal_o = imm12_ok;
         end
         KIND_SW: begin
            word_o  = {imm_i[11:5], rs2_i, rs1_i, F3_WORD, imm_i[4:0], OP_STORE};
            legal_o = imm12_ok;
         end
         KIND_RTYPE: begin
            word_o  = {(alu_sub ? F7_SUB : F7_DEFAULT), rs2_i, rs1_i, alu_f3, rd_i, OP_RTYPE};
            legal_o = alu_ok;
         end
         KIND_BEQ: begin
            word_o  = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, F3_BEQ,
                       imm_i[4:1], imm_i[11], OP_BRANCH};
            legal_o = imm13_ok;
         end
         KIND_ITYPE: begin
            // there is no subi; an ITYPE SUB request is rejected
            word_o  = {imm_i[11:0], rs1_i, alu_f3, rd_i, OP_ITYPE};
            legal_o = alu_ok & ~alu_sub & imm12_ok;
         end
         KIND_JAL: begin
            word_o  = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, OP_JAL};
            legal_o = imm21_ok;
         end
         KIND_LUI: begin
            word_o  = {imm_i[31:12], rd_i, OP_LUI};
            legal_o = lui_ok;
         end
         default: begin
            word_o  = 32'd0;
            legal_o = 1'b0;
         end
      endcase
   end
endmodule

// File: rtl/ucsbece154a_instr_encoder.sv
// Instruction encoder / imem program loader.
// Accepts field-level requests, encodes them into RV32I words and writes
// them to consecutive imem word addresses, one per cycle, one cycle after
// acceptance.
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   start_i         start a load session (pointer to BASE_ADDR, count/error cleared)
//   req             request bus (slave side)
//   we_o            imem write strobe
//   waddr_o         imem word address
//   wdata_o         encoded instruction
//   count_o         words written this session
//   full_o          count_o == DEPTH
//   error_o         sticky: an illegal request was dropped
//
// state   | meaning
// IDLE    | after reset, waiting for start_i
// RUN     | accepting requests
// FULL    | DEPTH words written, requests stalled until start_i
module ucsbece154a_instr_encoder #(
   parameter int ADDR_W    = 6,
   parameter int DEPTH     = 64,
   parameter int BASE_ADDR = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start_i,
   ucsbece154a_instr_encoder_if.slave req,
   output logic                  we_o,
   output logic [ADDR_W-1:0]     waddr_o,
   output logic [31:0]           wdata_o,
   output logic [ADDR_W:0]       count_o,
   output logic                  full_o,
   output logic                  error_o
);
   import ucsbece154a_instr_encoder_pkg::*;

   localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);
   localparam logic [ADDR_W:0]   CNT_LAST  = (ADDR_W+1)'(DEPTH - 1);
   localparam logic [ADDR_W:0]   CNT_DEPTH = (ADDR_W+1)'(DEPTH);

   enc_state_e        state_q, state_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] waddr_q, waddr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              error_q, error_d;

   logic              req_ready;
   logic              accept;
   logic [31:0]       word;
   logic              legal;

   ucsbece154a_instr_pack u_pack (
      .kind_i    (req.req_kind),
      .alu_sel_i (req.alu_sel),
      .rd_i      (req.rd),
      .rs1_i     (req.rs1),
      .rs2_i     (req.rs2),
      .imm_i     (req.imm),
      .word_o    (word),
      .legal_o   (legal)
   );

   // start_i takes priority over a same-cycle request
   assign req_ready     = (state_q == ST_RUN) & ~start_i;
   assign accept        = req.req_valid & req_ready;
   assign req.req_ready = req_ready;

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      we_d    = 1'b0;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      error_d = error_q;
      if (start_i) begin
         state_d = ST_RUN;
         count_d = '0;
         error_d = 1'b0;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (accept) begin
                  if (legal) begin
                     we_d    = 1'b1;
                     waddr_d = BASE + count_q[ADDR_W-1:0];
                     wdata_d = word;
                     count_d = count_q + CNT_ONE;
                     if (count_q == CNT_LAST) begin
                        state_d = ST_FULL;
                     end
                  end else begin
                     error_d = 1'b1;
                  end
               end
            end
            ST_IDLE: state_d = ST_IDLE;
            ST_FULL: state_d = ST_FULL;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         count_q <= '0;
         we_q    <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         we_q    <= we_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
         error_q <= error_d;
      end
   end

   assign we_o    = we_q;
   assign waddr_o = waddr_q;
   assign wdata_o = wdata_q;
   assign count_o = count_q;
   assign full_o  = (count_q == CNT_DEPTH);
   assign error_o = error_q;
endmodule
